router: RTL and testbench

ROUTER -- requirements
Module: router

---
 rtl/router_pkg.sv | 13 +
 rtl/route_table.sv | 57 +++++
 rtl/router.sv | 38 +++
 tb/tb_router.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths, routing-table entry layout and the miss port for the router block.
package router_pkg;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned PORT_W = 2;

  localparam logic [PORT_W-1:0] DEFAULT_PORT = 2'b00;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [PORT_W-1:0] port;
  } entry_t;
endpackage

// File: rtl/route_table.sv
// Routing table: entry storage, parallel address match, and FIFO-replacement insertion.
module route_table
  import router_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PORT_W-1:0] i_port,
  output logic              o_hit,
  output logic [PORT_W-1:0] o_port
);
  localparam int unsigned PTR_W = $clog2(N_ENTRIES);

  entry_t                 r_tbl [N_ENTRIES];
  logic [PTR_W-1:0]       r_ptr;
  logic [N_ENTRIES-1:0]   w_match;
  logic [PORT_W-1:0]      w_port;

  // At most one entry can match, so OR-ing matched ports yields the hit port.
  always_comb begin
    w_match = '0;
    w_port  = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (r_tbl[i].valid && (r_tbl[i].addr == i_addr)) begin
        w_match[i] = 1'b1;
        w_port     = w_port | r_tbl[i].port;
      end
    end
  end

  assign o_hit  = |w_match;
  assign o_port = w_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        r_tbl[i] <= '0;
      end
      r_ptr <= '0;
    end else if (i_wr) begin
      if (o_hit) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
          if (w_match[i]) begin
            r_tbl[i].port <= i_port;
          end
        end
      end else begin
        // Pointer wraps naturally (power-of-two depth), evicting the oldest insert.
        r_tbl[r_ptr] <= '{valid: 1'b1, addr: i_addr, port: i_port};
        r_ptr        <= r_ptr + PTR_W'(1);
      end
    end
  end
endmodule

// File: rtl/router.sv
// Address router: setup mode writes the route table, routing mode registers the looked-up port.
module router
  import router_pkg::*;
#(
  parameter int unsigned       N_ENTRIES    = 8,
  parameter logic [PORT_W-1:0] DEFAULT_PORT = router_pkg::DEFAULT_PORT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup,
  input  logic [ADDR_W-1:0] Address,
  input  logic [PORT_W-1:0] p,
  output logic [PORT_W-1:0] Port
);
  logic              w_hit;
  logic [PORT_W-1:0] w_port;

  route_table #(
    .N_ENTRIES (N_ENTRIES)
  ) u_table (
    .clk    (clk),
    .rst_n  (reset),
    .i_wr   (setup),
    .i_addr (Address),
    .i_port (p),
    .o_hit  (w_hit),
    .o_port (w_port)
  );

  // Port only updates on lookup edges; it holds through setup cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Port <= '0;
    end else if (!setup) begin
      Port <= w_hit ? w_port : DEFAULT_PORT;
    end
  end
endmodule

// File: tb/tb_router.sv
// Scoreboard bench for router: driver queues the expected Port per edge, monitor pops and compares.
module tb_router;
  logic       clk;
  logic       reset;
  logic       setup;
  logic [7:0] Address;
  logic [1:0] p;
  logic [1:0] Port;

  typedef struct {
    string      name;
    logic [1:0] exp;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  router #(
    .N_ENTRIES    (8),
    .DEFAULT_PORT (2'b00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .setup   (setup),
    .Address (Address),
    .p       (p),
    .Port    (Port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction per rising edge; expected Port after that edge is queued.
  task automatic cyc(input bit s, input logic [7:0] a, input logic [1:0] pp,
                     input string nm, input logic [1:0] exp);
    item_t it;
    @(negedge clk);
    setup   = s;
    Address = a;
    p       = pp;
    it.name = nm;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one queued expectation per rising edge while the driver is active.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        it = q.pop_front();
        chk(it.name, Port, it.exp);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    setup   = 1'b0;
    Address = '0;
    p       = '0;
    #12;
    chk("reset_state", Port, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Fill; Port holds its reset value through setup.
    cyc(1, 8'h2A, 2'd2, "fill_hold", 2'b00);
    cyc(1, 8'hDC, 2'd0, "fill_hold", 2'b00);
    cyc(1, 8'hF9, 2'd1, "fill_hold", 2'b00);
    cyc(1, 8'h29, 2'd1, "fill_hold", 2'b00);
    cyc(1, 8'hC6, 2'd2, "fill_hold", 2'b00);
    cyc(1, 8'hDB, 2'd3, "fill_hold", 2'b00);
    cyc(1, 8'h93, 2'd0, "fill_hold", 2'b00);
    cyc(1, 8'hAA, 2'd2, "fill_hold", 2'b00);
    cyc(0, 8'hDB, 2'd0, "lookup_DB", 2'd3);
    cyc(0, 8'hC6, 2'd0, "lookup_C6", 2'd2);
    cyc(0, 8'h77, 2'd0, "miss_77",   2'd0);
    cyc(0, 8'h77, 2'd0, "miss_77_held", 2'd0);

    // Overflow evicts 2A into entry 0.
    cyc(1, 8'h55, 2'd3, "ovf_hold",  2'd0);
    cyc(0, 8'h55, 2'd0, "lookup_55", 2'd3);
    cyc(0, 8'h2A, 2'd0, "evicted_2A", 2'd0);
    cyc(0, 8'hDC, 2'd0, "lookup_DC", 2'd0);

    // Update in place; next new address must evict DC (entry 1).
    cyc(1, 8'hDB, 2'd1, "upd_hold",  2'd0);
    cyc(0, 8'hDB, 2'd0, "upd_DB",    2'd1);
    cyc(1, 8'h66, 2'd2, "ins66_hold", 2'd1);
    cyc(0, 8'h66, 2'd0, "lookup_66", 2'd2);
    cyc(0, 8'hDC, 2'd0, "evicted_DC", 2'd0);
    cyc(0, 8'hF9, 2'd0, "lookup_F9", 2'd1);

    // Setup hold with a non-default Port value.
    cyc(0, 8'hC6, 2'd0, "lookup_C6b", 2'd2);
    cyc(1, 8'h11, 2'd3, "setup_hold_1", 2'd2);
    cyc(1, 8'h12, 2'd1, "setup_hold_2", 2'd2);
    cyc(0, 8'h11, 2'd0, "lookup_11", 2'd3);
    cyc(0, 8'h29, 2'd0, "evicted_29", 2'd0);
    cyc(0, 8'h12, 2'd0, "lookup_12", 2'd1);

    // Asynchronous reset between edges, with a lookup presented while held.
    @(negedge clk);
    setup   = 1'b0;
    Address = 8'hDB;
    #2 reset = 1'b0;
    #1 chk("reset_async", Port, 2'b00);
    @(posedge clk);
    #1 chk("reset_edge_hold", Port, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    cyc(0, 8'hDB, 2'd0, "post_rst_DB", 2'd0);
    cyc(0, 8'hC6, 2'd0, "post_rst_C6", 2'd0);
    cyc(1, 8'hDB, 2'd2, "rewrite_hold", 2'd0);
    cyc(0, 8'hDB, 2'd0, "rewrite_DB", 2'd2);

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
